i2c_slave_responder: RTL and testbench

//  Target (responder) end of the team's single-byte I2C link; pairs with the I2C master block.

---
 rtl/i2c_slave_responder.sv | 146 ++++++++++++++
 tb/tb_i2c_slave_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// Single-byte I2C target: 2-flop synced SCL/SDA, START/STOP detect, 7-bit address match with ACK,
// one-byte write receive or one-byte read return; SDA driven open-drain via o_sda_oe.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    input  logic [7:0] i_tx_data,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rd_req,
    output logic       o_master_ack,
    output logic       o_done,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    state_t     state_q;
    logic [2:0] scl_q, sda_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q, tx_q;
    logic       rw_q, ack_drv_q;

    // Edges compare the 3rd sync flop against the 2nd; bits are sampled from the 2nd.
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shift_d;
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    assign shift_d   = {shift_q[6:0], sda_q[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q        <= 3'b111;
            sda_q        <= 3'b111;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            tx_q         <= 8'h00;
            rw_q         <= 1'b0;
            ack_drv_q    <= 1'b0;
            o_sda_oe     <= 1'b0;
            o_rx_data    <= 8'h00;
            o_rx_valid   <= 1'b0;
            o_rd_req     <= 1'b0;
            o_master_ack <= 1'b0;
            o_done       <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            scl_q      <= {scl_q[1:0], i_scl};
            sda_q      <= {sda_q[1:0], i_sda};
            o_rx_valid <= 1'b0;
            o_rd_req   <= 1'b0;
            o_done     <= 1'b0;
            if (start_det) begin
                state_q   <= ADDR;
                bit_cnt_q <= 3'd0;
                o_sda_oe  <= 1'b0;
                o_busy    <= 1'b0;
            end else if (stop_det) begin
                state_q  <= IDLE;
                o_sda_oe <= 1'b0;
                o_busy   <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_d[7:1] == SLAVE_ADDR) begin
                                state_q   <= ADDR_ACK;
                                rw_q      <= shift_d[0];
                                ack_drv_q <= 1'b0;
                                o_busy    <= 1'b1;
                                o_rd_req  <= shift_d[0];
                            end else begin
                                state_q <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!ack_drv_q) begin
                            ack_drv_q <= 1'b1;
                            o_sda_oe  <= 1'b1;
                        end else if (rw_q) begin
                            // Read data MSB goes out on the same fall that ends the ACK.
                            tx_q      <= i_tx_data;
                            o_sda_oe  <= ~i_tx_data[7];
                            bit_cnt_q <= 3'd0;
                            state_q   <= RD_BYTE;
                        end else begin
                            o_sda_oe  <= 1'b0;
                            bit_cnt_q <= 3'd0;
                            state_q   <= WR_BYTE;
                        end
                    end
                    WR_BYTE: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            o_rx_data  <= shift_d;
                            o_rx_valid <= 1'b1;
                            ack_drv_q  <= 1'b0;
                            state_q    <= WR_ACK;
                        end
                    end
                    WR_ACK: if (scl_fall) begin
                        if (!ack_drv_q) begin
                            ack_drv_q <= 1'b1;
                            o_sda_oe  <= 1'b1;
                        end else begin
                            o_sda_oe <= 1'b0;
                            o_done   <= 1'b1;
                            state_q  <= WAIT_STOP;
                        end
                    end
                    RD_BYTE: if (scl_fall) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            o_sda_oe <= 1'b0;
                            state_q  <= RD_ACK;
                        end else begin
                            o_sda_oe <= ~tx_q[6];
                            tx_q     <= {tx_q[6:0], 1'b0};
                        end
                    end
                    RD_ACK: if (scl_rise) begin
                        o_master_ack <= ~sda_q[1];
                        o_done       <= 1'b1;
                        state_q      <= WAIT_STOP;
                    end
                    IDLE, WAIT_STOP: o_sda_oe <= 1'b0;
                    default:         state_q  <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master with open-drain bus model, pulse monitors, hand-computed expectations.
module tb_i2c_slave_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl, sda_m;
    logic       sda_bus;
    logic       o_sda_oe;
    logic [7:0] i_tx_data;
    logic [7:0] o_rx_data;
    logic       o_rx_valid, o_rd_req, o_master_ack, o_done, o_busy;

    int n_vec  = 0;
    int n_miss = 0;

    logic clr_mon;
    int   n_rxv, n_rdq, n_done;
    logic busy_seen, oe_seen;

    assign sda_bus = sda_m & ~o_sda_oe;

    always #5 clk = ~clk;

    i2c_slave_responder #(.SLAVE_ADDR(7'h50)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_scl        (scl),
        .i_sda        (sda_bus),
        .o_sda_oe     (o_sda_oe),
        .i_tx_data    (i_tx_data),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
        .o_rd_req     (o_rd_req),
        .o_master_ack (o_master_ack),
        .o_done       (o_done),
        .o_busy       (o_busy)
    );

    always @(posedge clk) begin
        if (clr_mon) begin
            n_rxv     <= 0;
            n_rdq     <= 0;
            n_done    <= 0;
            busy_seen <= 1'b0;
            oe_seen   <= 1'b0;
        end else begin
            if (o_rx_valid) n_rxv <= n_rxv + 1;
            if (o_rd_req)   n_rdq <= n_rdq + 1;
            if (o_done)     n_done <= n_done + 1;
            if (o_busy)     busy_seen <= 1'b1;
            if (o_sda_oe)   oe_seen <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        clr_mon = 1'b1;
        wclk(1);
        clr_mon = 1'b0;
    endtask

    task automatic start_cond();
        sda_m = 1'b1; wclk(4);
        scl   = 1'b1; wclk(8);
        sda_m = 1'b0; wclk(8);
        scl   = 1'b0; wclk(4);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; wclk(4);
        scl   = 1'b1; wclk(8);
        sda_m = 1'b1; wclk(8);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wclk(4);
        scl   = 1'b1; wclk(8);
        scl   = 1'b0; wclk(4);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wclk(4);
        scl   = 1'b1; wclk(4);
        b     = sda_bus; wclk(4);
        scl   = 1'b0; wclk(4);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic acked);
        logic x;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(x);
        acked = ~x;
    endtask

    task automatic rd_byte(output logic [7:0] d);
        logic x;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(x);
            d = {d[6:0], x};
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] addr_r;
        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; i_tx_data = 8'h00; clr_mon = 1'b1;
        wclk(4);
        rst_n = 1'b1;
        wclk(4);
        check("rst_oe",    {31'd0, o_sda_oe}, 0);
        check("rst_rxd",   {24'd0, o_rx_data}, 32'h00);
        check("rst_pulse", {29'd0, o_rx_valid, o_rd_req, o_done}, 0);
        check("rst_mack",  {31'd0, o_master_ack}, 0);
        check("rst_busy",  {31'd0, o_busy}, 0);

        // Write 0x50/W, 0xA5
        clear_mon();
        start_cond();
        wr_byte(8'hA0, ack);
        check("wr_addr_ack", {31'd0, ack}, 1);
        check("wr_busy", {31'd0, o_busy}, 1);
        wr_byte(8'hA5, ack);
        check("wr_data_ack", {31'd0, ack}, 1);
        stop_cond();
        check("wr_rxd",   {24'd0, o_rx_data}, 32'hA5);
        check("wr_rxv_n", n_rxv, 1);
        check("wr_done_n", n_done, 1);
        check("wr_rdq_n", n_rdq, 0);
        check("wr_busy_end", {31'd0, o_busy}, 0);
        check("wr_oe_end", {31'd0, o_sda_oe}, 0);

        // Read 0x50/R returning 0x3C, master NACK
        i_tx_data = 8'h3C;
        clear_mon();
        start_cond();
        wr_byte(8'hA1, ack);
        check("rd_addr_ack", {31'd0, ack}, 1);
        rd_byte(rd);
        check("rd_data_3c", {24'd0, rd}, 32'h3C);
        write_bit(1'b1);
        stop_cond();
        check("rd_rdq_n", n_rdq, 1);
        check("rd_mack_nack", {31'd0, o_master_ack}, 0);
        check("rd_done_n", n_done, 1);
        check("rd_rxv_n", n_rxv, 0);
        check("rd_oe_end", {31'd0, o_sda_oe}, 0);

        // Wrong address 0x51/W
        clear_mon();
        start_cond();
        wr_byte(8'hA2, ack);
        check("na_addr_nack", {31'd0, ack}, 0);
        wr_byte(8'hFF, ack);
        stop_cond();
        check("na_oe_seen", {31'd0, oe_seen}, 0);
        check("na_rxv_n", n_rxv, 0);
        check("na_busy_seen", {31'd0, busy_seen}, 0);

        // Write address, repeated START, read 0x81 with master ACK
        i_tx_data = 8'h81;
        clear_mon();
        start_cond();
        wr_byte(8'hA0, ack);
        check("rs_waddr_ack", {31'd0, ack}, 1);
        start_cond();
        wr_byte(8'hA1, ack);
        check("rs_raddr_ack", {31'd0, ack}, 1);
        rd_byte(rd);
        check("rs_data_81", {24'd0, rd}, 32'h81);
        write_bit(1'b0);
        stop_cond();
        check("rs_rxv_n", n_rxv, 0);
        check("rs_rdq_n", n_rdq, 1);
        check("rs_mack_ack", {31'd0, o_master_ack}, 1);
        check("rs_rxd_kept", {24'd0, o_rx_data}, 32'hA5);

        // STOP after 4 data bits of a write
        clear_mon();
        start_cond();
        wr_byte(8'hA0, ack);
        check("ab_addr_ack", {31'd0, ack}, 1);
        write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
        stop_cond();
        check("ab_rxd_kept", {24'd0, o_rx_data}, 32'hA5);
        check("ab_rxv_n", n_rxv, 0);
        check("ab_oe", {31'd0, o_sda_oe}, 0);
        check("ab_busy", {31'd0, o_busy}, 0);

        // Reset asserted while the responder is pulling SDA in a read's ACK slot
        i_tx_data = 8'h3C;
        start_cond();
        addr_r = 8'hA1;
        for (int i = 7; i >= 0; i--) write_bit(addr_r[i]);
        sda_m = 1'b1; wclk(4);
        scl   = 1'b1; wclk(4);
        check("pre_rst_oe", {31'd0, o_sda_oe}, 1);
        rst_n = 1'b0;
        #1;
        check("arst_oe",   {31'd0, o_sda_oe}, 0);
        check("arst_busy", {31'd0, o_busy}, 0);
        check("arst_rxd",  {24'd0, o_rx_data}, 32'h00);
        check("arst_mack", {31'd0, o_master_ack}, 0);
        check("arst_pulse", {29'd0, o_rx_valid, o_rd_req, o_done}, 0);
        wclk(2);
        rst_n = 1'b1;
        scl = 1'b0; wclk(4);
        stop_cond();
        check("post_rst_oe", {31'd0, o_sda_oe}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
